// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage
// Description : Registered ALU output stage with zero/negative flags and a
//               two-entry skid buffer on a valid/ready handshake.
//               Optional macro ALU_STAGE_OVERFLOW_EN adds signed-add overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_stage #(
   parameter int WORD_LENGTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WORD_LENGTH-1:0] alu_result,
   input  logic                   alu_carry,
   input  logic [3:0]             alu_control,
`ifdef ALU_STAGE_OVERFLOW_EN
   input  logic                   alu_sign_a,
   input  logic                   alu_sign_b,
   output logic                   out_overflow,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WORD_LENGTH-1:0] out_result,
   output logic                   out_carry,
   output logic                   out_zero,
   output logic                   out_negative,
   output logic [3:0]             out_control
);

`ifdef ALU_STAGE_OVERFLOW_EN
   localparam int ENTRY_W = WORD_LENGTH + 8;
`else
   localparam int ENTRY_W = WORD_LENGTH + 7;
`endif

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_TWO   = 2'd2;

   logic [1:0]         r_state;
   logic [1:0]         w_state_next;
   logic               r_in_ready;
   logic [ENTRY_W-1:0] r_main;
   logic [ENTRY_W-1:0] r_skid;
   logic [ENTRY_W-1:0] w_main_next;
   logic [ENTRY_W-1:0] w_skid_next;
   logic [ENTRY_W-1:0] w_in_entry;
   logic               w_accept;
   logic               w_pop;
   logic               w_zero;
   logic               w_negative;

   assign w_accept = in_valid & r_in_ready;
   assign w_pop    = out_valid & out_ready;

   // Subtract returns a magnitude, so its sign lives in the carry/borrow bit.
   assign w_zero     = (alu_result == '0);
   assign w_negative = (alu_control == 4'b0001) ? alu_carry : alu_result[WORD_LENGTH-1];

`ifdef ALU_STAGE_OVERFLOW_EN
   logic w_overflow;
   assign w_overflow = (alu_control == 4'b0010) && (alu_sign_a == alu_sign_b) &&
                       (alu_result[WORD_LENGTH-1] != alu_sign_a);
   assign w_in_entry = {w_overflow, alu_control, w_negative, w_zero, alu_carry, alu_result};
`else
   assign w_in_entry = {alu_control, w_negative, w_zero, alu_carry, alu_result};
`endif

   always_comb begin
      w_state_next = r_state;
      w_main_next  = r_main;
      w_skid_next  = r_skid;
      if (flush) begin
         w_state_next = S_EMPTY;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_accept) begin
                  w_main_next  = w_in_entry;
                  w_state_next = S_ONE;
               end
            end
            S_ONE: begin
               if (w_accept && w_pop) begin
                  w_main_next = w_in_entry;
               end else if (w_accept) begin
                  w_skid_next  = w_in_entry;
                  w_state_next = S_TWO;
               end else if (w_pop) begin
                  w_state_next = S_EMPTY;
               end
            end
            S_TWO: begin
               if (w_pop) begin
                  w_main_next  = r_skid;
                  w_state_next = S_ONE;
               end
            end
            default: w_state_next = S_EMPTY;
         endcase
      end
   end

   // in_ready is registered from the next state so downstream ready never
   // reaches the ALU combinationally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_EMPTY;
         r_in_ready <= 1'b1;
         r_main     <= '0;
         r_skid     <= '0;
      end else begin
         r_state    <= w_state_next;
         r_in_ready <= (w_state_next != S_TWO);
         r_main     <= w_main_next;
         r_skid     <= w_skid_next;
      end
   end

   assign in_ready     = r_in_ready;
   assign out_valid    = (r_state != S_EMPTY);
   assign out_result   = r_main[WORD_LENGTH-1:0];
   assign out_carry    = r_main[WORD_LENGTH];
   assign out_zero     = r_main[WORD_LENGTH+1];
   assign out_negative = r_main[WORD_LENGTH+2];
   assign out_control  = r_main[WORD_LENGTH+6:WORD_LENGTH+3];
`ifdef ALU_STAGE_OVERFLOW_EN
   assign out_overflow = r_main[WORD_LENGTH+7];
`endif

endmodule
`default_nettype wire
